uart_fread_responder: RTL and testbench

- Captures a byte image arriving from the UART receiver into on-chip RAM as 16-bit words.
- Once the image is complete, it answers "fread"-style chunk requests on a req/resp stream, acting as the responder that a loader such as the ESP-side initiator talks to.
- Sits between the UART RX byte stream and any fabric block that issues offset-based chunk reads.
- Used for bench loopback and for serving images without the ESP.

---
 rtl/uart_fread_responder_if.sv | 27 ++
 rtl/uart_fread_responder.sv | 134 +++++++++++++
 tb/tb_uart_fread_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fread_responder_if.sv
// Groups the UART capture strobe, the chunk request stream and the response byte stream.
// Latency: none, this file only declares wires.
// Backpressure: req_ready and resp_ready carry the handshakes; the UART strobe cannot be stalled.
interface uart_fread_responder_if;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_offset;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        loaded;
  logic        busy;

  // Initiator side: feeds bytes, issues requests, consumes responses.
  modport master (
    output uart_data, uart_valid, req_valid, req_offset, resp_ready,
    input  req_ready, resp_data, resp_valid, loaded, busy
  );

  // Responder side.
  modport slave (
    input  uart_data, uart_valid, req_valid, req_offset, resp_ready,
    output req_ready, resp_data, resp_valid, loaded, busy
  );
endinterface

// File: rtl/uart_fread_responder.sv
// Captures a UART byte image into 16-bit RAM, then serves fixed-size chunk reads by byte offset.
// Latency: first response byte 2 cycles after request acceptance, then one byte per cycle.
// Backpressure: resp_ready stalls a prefetch pipeline with the held byte stable; requests refused while serving.
module uart_fread_responder #(
  parameter int unsigned DEPTH = 6144,
  parameter int unsigned CHUNK = 2048,
  parameter logic [7:0]  FILL  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_fread_responder_if.slave  bus
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = $clog2(CHUNK + 1);
  localparam logic [15:0]   LAST_BC   = 16'(2 * DEPTH - 1);
  localparam logic [31:0]   IMG_BYTES = 32'(2 * DEPTH);
  localparam logic [CW-1:0] CHUNK_N   = CW'(CHUNK);

  typedef enum logic [1:0] {LOAD, IDLE, SERVE} state_t;

  state_t         state;
  logic [15:0]    bc;
  logic [7:0]     low_byte;
  logic [31:0]    off;
  logic [CW-1:0]  iss;
  logic [CW-1:0]  rem;
  logic [15:0]    mem [DEPTH];
  logic [15:0]    ram_q;
  logic           p_vld;
  logic           p_sel;
  logic           p_fill;

  logic [31:0]    rd_addr;
  logic           rd_in_range;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  wr_idx;
  logic           wr_en;
  logic           out_adv;
  logic           p_adv;
  logic           issue;
  logic           resp_hs;

  // Address of the next byte to fetch; the 32-bit sum wraps naturally.
  assign rd_addr     = off + 32'(iss);
  assign rd_in_range = rd_addr < IMG_BYTES;
  // Out-of-image addresses never reach the RAM index; they become FILL bytes.
  assign rd_idx      = rd_in_range ? rd_addr[AW:1] : '0;
  assign wr_idx      = bc[AW:1];
  assign wr_en       = ~rst && (state == LOAD) && bus.uart_valid && bc[0];

  // Output slot frees when empty or being consumed; the fetch stage moves whenever it can hand off.
  assign out_adv     = ~bus.resp_valid | bus.resp_ready;
  assign p_adv       = ~p_vld | out_adv;
  assign issue       = (state == SERVE) && p_adv && (iss < CHUNK_N);
  assign resp_hs     = bus.resp_valid & bus.resp_ready;

  assign bus.req_ready = (state == IDLE);

  // Image RAM: word write on the odd byte of each pair, registered read gated by the fetch enable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= {bus.uart_data, low_byte};
    if (issue) ram_q <= mem[rd_idx];
  end

  // Control FSM: image capture, request acceptance and the two-stage response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      bc             <= '0;
      low_byte       <= '0;
      off            <= '0;
      iss            <= '0;
      rem            <= '0;
      p_vld          <= 1'b0;
      p_sel          <= 1'b0;
      p_fill         <= 1'b0;
      bus.loaded     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.uart_valid) begin
            bc <= bc + 16'd1;
            if (!bc[0]) low_byte <= bus.uart_data;
            if (bc == LAST_BC) begin
              state      <= IDLE;
              bus.loaded <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (bus.req_valid) begin
            off      <= bus.req_offset;
            iss      <= '0;
            rem      <= CHUNK_N;
            p_vld    <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SERVE;
          end
        end
        SERVE: begin
          // Fetch stage: launch the next RAM read while the current byte is presented.
          if (p_adv) begin
            p_vld <= issue;
            if (issue) begin
              p_sel  <= rd_addr[0];
              p_fill <= ~rd_in_range;
              iss    <= iss + 1'b1;
            end
          end
          // Output stage: pick the byte lane of the fetched word, or FILL past the image.
          if (out_adv) begin
            bus.resp_valid <= p_vld;
            if (p_vld) bus.resp_data <= p_fill ? FILL : (p_sel ? ram_q[15:8] : ram_q[7:0]);
          end
          if (resp_hs) begin
            rem <= rem - 1'b1;
            if (rem == CW'(1)) begin
              state          <= IDLE;
              bus.busy       <= 1'b0;
              bus.resp_valid <= 1'b0;
              p_vld          <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fread_responder.sv
// Bench for uart_fread_responder: loads byte images and checks chunk reads against a byte-array model.
// Latency: checks first-byte latency and gap-free streaming with resp_ready held high.
// Backpressure: random resp_ready stalls with byte stability checks.
module tb_uart_fread_responder;
  localparam int IMG   = 12288;
  localparam int CHUNK = 2048;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] img [IMG];

  uart_fread_responder_if bus();

  uart_fread_responder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int kind, input int k);
    logic [15:0] kk;
    logic [15:0] m;
    kk = k[15:0];
    m  = kk * 16'd13 + 16'd7;
    return (kind == 0) ? (kk[7:0] ^ kk[15:8]) : (m[7:0] ^ 8'h5A);
  endfunction

  // Reference: any address inside the image is its captured byte, anything else is FILL.
  function automatic logic [7:0] exp_byte(input logic [31:0] a);
    return (a < 32'(IMG)) ? img[a] : 8'hFF;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.uart_data = '0; bus.uart_valid = 1'b0; bus.req_valid = 1'b0;
    bus.req_offset = '0; bus.resp_ready = 1'b0;
    repeat (3) step();
    checks++; if (bus.req_ready !== 1'b0)  begin errors++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 8'h00) begin errors++; $display("FAIL reset_resp_data got %h want 00", bus.resp_data); end
    checks++; if (bus.loaded !== 1'b0)     begin errors++; $display("FAIL reset_loaded got %b want 0", bus.loaded); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    step();
  endtask

  // Streams n bytes of a pattern with occasional idle gaps; a full image is checked for completion timing.
  task automatic test_load(input int kind, input int n, input string name);
    int early_rdy = 0;
    int early_ld  = 0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.uart_valid = 1'b0;
        step();
      end
      if (bus.req_ready !== 1'b0) early_rdy++;
      if (bus.loaded !== 1'b0) early_ld++;
      bus.uart_data  = pat(kind, k);
      bus.uart_valid = 1'b1;
      img[k] = pat(kind, k);
      step();
      bus.uart_valid = 1'b0;
    end
    checks++; if (early_rdy !== 0) begin errors++; $display("FAIL %s req_ready_during_load got %0d cycles want 0", name, early_rdy); end
    checks++; if (early_ld !== 0)  begin errors++; $display("FAIL %s loaded_early got %0d cycles want 0", name, early_ld); end
    if (n == IMG) begin
      checks++; if (bus.loaded !== 1'b1)    begin errors++; $display("FAIL %s loaded_after_last got %b want 1", name, bus.loaded); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready_after_load got %b want 1", name, bus.req_ready); end
    end
  endtask

  task automatic test_partial_load_reset();
    test_load(1, 50, "partial_load");
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.loaded !== 1'b0) begin errors++; $display("FAIL partial_reset_loaded got %b want 0", bus.loaded); end
  endtask

  task automatic test_extra_bytes();
    for (int k = 0; k < 8; k++) begin
      bus.uart_data  = 8'($urandom);
      bus.uart_valid = 1'b1;
      step();
    end
    bus.uart_valid = 1'b0;
    checks++; if (bus.loaded !== 1'b1) begin errors++; $display("FAIL extra_bytes_loaded got %b want 1", bus.loaded); end
  endtask

  task automatic test_serve(input logic [31:0] offs, input bit stall, input string name);
    int waited = 0;
    int lat = 0;
    int got = 0;
    int cyc = 0;
    int bad = 0;
    int first_bad = -1;
    logic [7:0] fb_got = '0;
    logic [7:0] fb_exp = '0;
    int stall_err = 0;
    bit held = 1'b0;
    logic [7:0] held_dat = '0;
    bit rdy;
    while (!bus.req_ready && waited < 100) begin step(); waited++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_wait got %b want 1", name, bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1; bus.req_offset = offs; bus.resp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b want 1", name, bus.busy); end
    while (!bus.resp_valid && lat < 20) begin step(); lat++; end
    checks++; if (lat > 2) begin errors++; $display("FAIL %s first_latency got %0d cycles want <=2", name, lat); end
    while (got < CHUNK && cyc < 20000) begin
      rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.resp_ready = rdy;
      if (held && (bus.resp_valid !== 1'b1 || bus.resp_data !== held_dat)) stall_err++;
      if (bus.resp_valid && rdy) begin
        if (bus.resp_data !== exp_byte(offs + 32'(got))) begin
          if (bad == 0) begin first_bad = got; fb_got = bus.resp_data; fb_exp = exp_byte(offs + 32'(got)); end
          bad++;
        end
        got++;
        held = 1'b0;
      end else if (bus.resp_valid) begin
        held = 1'b1; held_dat = bus.resp_data;
      end else begin
        held = 1'b0;
      end
      step();
      cyc++;
    end
    bus.resp_ready = 1'b0;
    checks++; if (got !== CHUNK) begin errors++; $display("FAIL %s byte_count got %0d want %0d", name, got, CHUNK); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s data at index %0d got %h want %h (%0d bad)", name, first_bad, fb_got, fb_exp, bad); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL %s resp_valid_after got %b want 0", name, bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready_after got %b want 1", name, bus.req_ready); end
    if (stall) begin
      checks++; if (stall_err !== 0) begin errors++; $display("FAIL %s stall_stability got %0d violations want 0", name, stall_err); end
    end else begin
      checks++; if (cyc !== CHUNK) begin errors++; $display("FAIL %s stream_cycles got %0d want %0d", name, cyc, CHUNK); end
    end
  endtask

  // Request held high across two chunks with UART noise; one acceptance per chunk, RAM untouched.
  task automatic test_req_held(input logic [31:0] offs);
    int acc = 0;
    int got = 0;
    int cyc = 0;
    int bad = 0;
    bus.req_valid = 1'b1; bus.req_offset = offs; bus.resp_ready = 1'b1;
    while (got < 2 * CHUNK && cyc < 10000) begin
      bus.uart_valid = 1'b1;
      bus.uart_data  = 8'($urandom);
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.resp_valid) begin
        if (bus.resp_data !== exp_byte(offs + 32'(got % CHUNK))) bad++;
        got++;
      end
      step();
      cyc++;
    end
    bus.req_valid = 1'b0; bus.uart_valid = 1'b0; bus.resp_ready = 1'b0;
    checks++; if (got !== 2 * CHUNK) begin errors++; $display("FAIL req_held_bytes got %0d want %0d", got, 2 * CHUNK); end
    checks++; if (acc !== 2) begin errors++; $display("FAIL req_held_acceptances got %0d want 2", acc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL req_held_data got %0d bad bytes want 0", bad); end
    test_serve(32'h0000_1000, 1'b0, "ram_unchanged");
  endtask

  task automatic test_reset_mid_serve();
    int got = 0;
    int cyc = 0;
    int waited = 0;
    while (!bus.req_ready && waited < 100) begin step(); waited++; end
    bus.req_valid = 1'b1; bus.req_offset = 32'h0; bus.resp_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    while (got < 100 && cyc < 1000) begin
      if (bus.resp_valid) got++;
      step();
      cyc++;
    end
    checks++; if (got !== 100) begin errors++; $display("FAIL mid_serve_bytes got %0d want 100", got); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.resp_ready = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_serve_resp_valid got %b want 0", bus.resp_valid); end
    checks++; if (bus.loaded !== 1'b0)     begin errors++; $display("FAIL mid_serve_loaded got %b want 0", bus.loaded); end
    checks++; if (bus.req_ready !== 1'b0)  begin errors++; $display("FAIL mid_serve_req_ready got %b want 0", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL mid_serve_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_partial_load_reset();
    test_load(0, IMG, "load_pat0");
    test_extra_bytes();
    test_serve(32'h0000_0000, 1'b0, "serve_off0");
    test_serve(32'h0000_0801, 1'b1, "serve_odd_stall");
    test_serve(32'h0000_2C00, 1'b1, "serve_straddle");
    test_serve(32'hFFFF_FC00, 1'b0, "serve_wrap");
    test_req_held(32'($urandom_range(0, IMG - 1)));
    test_reset_mid_serve();
    test_load(1, IMG, "reload_pat1");
    test_serve(32'h0000_0100, 1'b0, "serve_new_pat");
    test_serve(32'($urandom_range(0, IMG + 1000)), 1'b1, "serve_random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
